// File: rtl/div32_pkg.sv
// Shared types and constants for the div32 restoring divider.
package div32_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
   localparam logic [DIV_WIDTH-1:0] INT_MIN       = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div32_if.sv
// Request/result bundle between the execute stage and the divider.
interface div32_if #(parameter int WIDTH = div32_pkg::DIV_WIDTH);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_op;
   logic             valid;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             ready;

   modport master (output a, b, signed_op, valid, input quot, rem, ready);
   modport slave  (input a, b, signed_op, valid, output quot, rem, ready);
endinterface

// File: rtl/div32_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract.
module div_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] r,
   input  logic             msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] r_next,
   output logic             qbit
);
   logic [WIDTH:0] shifted;

   // shifted < 2*dvs, so the extra bit keeps the compare exact and the
   // difference always fits back into WIDTH bits.
   assign shifted = {r, msb};
   assign qbit    = (shifted >= {1'b0, dvs});
   assign r_next  = qbit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
endmodule

// File: rtl/div32.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Signed support is built only when DIV32_SIGNED_EN is defined.
//
// state   | meaning
// IDLE    | waiting for valid; special cases finish here directly
// RUN     | one restoring step per edge, WIDTH steps
// FIX     | sign fixup, write quot/rem, pulse ready
module div32
   import div32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic     clk,
   input logic     resetn,
   div32_if.slave  s
);
   localparam int CW = $clog2(WIDTH) + 1;

   state_e           state_q, state_d;
   logic             accept, special, ovf, last_step;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] r_q, dvd_q, dvs_q, quot_q, rem_q;
   logic [WIDTH-1:0] r_next;
   logic             qbit;
   logic [CW-1:0]    cnt_q;
   logic             ready_q;

`ifdef DIV32_SIGNED_EN
   logic sgn, qneg_q, rneg_q;
   assign sgn   = s.signed_op;
   assign ovf   = sgn && (s.a == INT_MIN) && (s.b == DIV_ZERO_QUOT);
   assign a_mag = (sgn && s.a[WIDTH-1]) ? -s.a : s.a;
   assign b_mag = (sgn && s.b[WIDTH-1]) ? -s.b : s.b;
`else
   logic unused_signed;
   assign unused_signed = s.signed_op;
   assign ovf   = 1'b0;
   assign a_mag = s.a;
   assign b_mag = s.b;
`endif

   assign special   = (s.b == '0) || ovf;
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_q),
      .msb    (dvd_q[WIDTH-1]),
      .dvs    (dvs_q),
      .r_next (r_next),
      .qbit   (qbit)
   );

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: if (s.valid) begin
            accept = 1'b1;
            if (!special) state_d = ST_RUN;
         end
         ST_RUN:  if (last_step) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_q     <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         ready_q <= 1'b0;
`ifdef DIV32_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         ready_q <= 1'b0;
         if (accept) begin
            if (s.b == '0) begin
               quot_q  <= DIV_ZERO_QUOT;
               rem_q   <= s.a;
               ready_q <= 1'b1;
            end else if (ovf) begin
               quot_q  <= INT_MIN;
               rem_q   <= '0;
               ready_q <= 1'b1;
            end else begin
               dvd_q <= a_mag;
               dvs_q <= b_mag;
               r_q   <= '0;
               cnt_q <= '0;
`ifdef DIV32_SIGNED_EN
               qneg_q <= sgn & (s.a[WIDTH-1] ^ s.b[WIDTH-1]);
               rneg_q <= sgn & s.a[WIDTH-1];
`endif
            end
         end else if (state_q == ST_RUN) begin
            // dividend register doubles as the quotient shift register
            r_q   <= r_next;
            dvd_q <= {dvd_q[WIDTH-2:0], qbit};
            cnt_q <= cnt_q + 1'b1;
         end else if (state_q == ST_FIX) begin
`ifdef DIV32_SIGNED_EN
            quot_q <= qneg_q ? -dvd_q : dvd_q;
            rem_q  <= rneg_q ? -r_q : r_q;
`else
            quot_q <= dvd_q;
            rem_q  <= r_q;
`endif
            ready_q <= 1'b1;
         end
      end
   end

   assign s.quot  = quot_q;
   assign s.rem   = rem_q;
   assign s.ready = ready_q;

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: arithmetic reference model plus per-cycle compare.
module tb_div32;
   import div32_pkg::*;

   localparam int W = 32;
`ifdef DIV32_SIGNED_EN
   localparam bit SEN = 1'b1;
`else
   localparam bit SEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   div32_if #(.WIDTH(W)) bus ();
   div32 #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .s(bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expected-result state shared by driver and compare process
   logic [31:0] exp_q, exp_r, held_q, held_r;
   int          exp_ready_cyc = -1;
   bit          started = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                 output logic [31:0] q, output logic [31:0] r, output int lat);
      bit sg;
      sg = s && SEN;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 0;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0; lat = 0;
      end else if (sg) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
         lat = 33;
      end else begin
         q = a / b; r = a % b; lat = 33;
      end
   endfunction

   always @(negedge clk) begin
      if (started) begin
         if (cyc == exp_ready_cyc) begin
            check("ready_pulse", {31'd0, bus.ready}, 32'd1);
            check("quot", bus.quot, exp_q);
            check("rem", bus.rem, exp_r);
            held_q = exp_q;
            held_r = exp_r;
         end else begin
            check("ready_low", {31'd0, bus.ready}, 32'd0);
            check("quot_hold", bus.quot, held_q);
            check("rem_hold", bus.rem, held_r);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      held_q = 32'd0;
      held_r = 32'd0;
      exp_ready_cyc = -1;
      started = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic idle(input int n);
      bus.valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Issues a request (DUT assumed idle at the next edge) and returns on the
   // negedge where ready is seen, with valid still high.
   task automatic op(input logic [31:0] a, input logic [31:0] b, input bit s,
                     input logic [31:0] wq, input logic [31:0] wr, input int wlat, input bit mutate);
      logic [31:0] mq, mr;
      int ml, c0;
      bit seen;
      model(a, b, s, mq, mr, ml);
      check("model_q", mq, wq);
      check("model_r", mr, wr);
      check("model_lat", ml, wlat);
      bus.a = a; bus.b = b; bus.signed_op = s; bus.valid = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      exp_q = mq;
      exp_r = mr;
      exp_ready_cyc = c0 + ml;
      seen = 1'b0;
      for (int i = 0; i < 45 && !seen; i++) begin
         @(negedge clk);
         if (bus.ready) seen = 1'b1;
         else if (mutate) begin
            bus.a = $urandom;
            bus.b = $urandom;
         end
      end
      if (!seen) check("ready_timeout", 32'd0, 32'd1);
      else       check("latency", cyc - c0, wlat);
   endtask

   initial begin
      bus.a = '0; bus.b = '0; bus.signed_op = 1'b0; bus.valid = 1'b0;
      repeat (3) @(negedge clk);
      do_reset();
      check("rst_quot", bus.quot, 32'd0);
      check("rst_rem", bus.rem, 32'd0);
      idle(2);

      op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);
      idle(2);
      op(32'hFFFF_FFF9, 32'd2, 1'b1, SEN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
         SEN ? 32'hFFFF_FFFF : 32'd1, 33, 1'b0);
      idle(2);
      op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, SEN ? 32'd3 : 32'd0,
         SEN ? 32'hFFFF_FFFF : 32'hFFFF_FFF9, 33, 1'b0);
      idle(2);
      op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1'b0);
      idle(2);
      op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1'b0);
      idle(2);
      op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, SEN ? 32'h8000_0000 : 32'd0,
         SEN ? 32'd0 : 32'h8000_0000, SEN ? 0 : 33, 1'b0);
      idle(2);
      op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33, 1'b0);
      idle(2);

      // reset lands on the 10th edge after accept; the run must vanish silently
      bus.a = 32'd1000; bus.b = 32'd3; bus.signed_op = 1'b0; bus.valid = 1'b1;
      @(posedge clk);
      #1;
      exp_q = 32'd333;
      exp_r = 32'd1;
      exp_ready_cyc = cyc + 33;
      bus.valid = 1'b0;
      repeat (9) @(posedge clk);
      do_reset();
      idle(40);
      check("midrst_quot", bus.quot, 32'd0);
      check("midrst_rem", bus.rem, 32'd0);
      op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);
      idle(2);

      // valid held with churning operands, then back-to-back requests
      op(32'd50000, 32'd7, 1'b0, 32'd7142, 32'd6, 33, 1'b1);
      op(32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 32'h000D_EADB, 32'h0000_0EEF, 33, 1'b0);
      op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 0, 1'b0);
      op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
